mem_dev: RTL and testbench
==========================

MEM_DEV -- requirements
Module: mem_dev

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cs_n, input, 1, chip select, low = command valid.
REQ-004 SHALL have port command, input, 3, opcode: NOP 000, ACT 001, READ 010, WRITE 011, PRE 100, REFRESH 101, 110/111 reserved.
REQ-005 SHALL have port RA, input, 4, row address.
REQ-006 SHALL have port CA, input, 12, column address.
REQ-007 SHALL have port DQ, inout, 32, data bus: sampled on WRITE, driven for read data only.
REQ-008 SHALL have port rd_vld, output, 1, high in the cycle the device drives DQ.
REQ-009 SHALL have port row_open, output, 1, a row is currently active.
REQ-010 SHALL have port open_row, output, 4, address of the active row.
REQ-011 SHALL have port busy, output, 1, refresh in progress.
REQ-012 SHALL have port err_vld, output, 1, one-cycle protocol-error pulse.
REQ-013 SHALL have port err_code, output, 3, error cause, valid with err_vld.
REQ-014 SHALL have port err_cnt, output, 8, saturating error count.
REQ-015 SHALL have port refresh_late, output, 1, sticky refresh-interval violation.

Function
REQ-016 SHALL hold a 65536 x 32 array addressed {open_row, CA}; contents not reset.
REQ-017 SHALL treat cs_n=1 as NOP regardless of command.
REQ-018 SHALL run states IDLE (no row open), ACTIVE (row open), RFSH (busy).
REQ-019 SHALL on ACT in IDLE latch RA into open_row and set row_open in the next cycle (ACTIVE); a READ/WRITE is legal the following cycle.
REQ-020 SHALL on PRE return to IDLE and clear row_open; PRE in IDLE is a legal no-op.
REQ-021 SHALL on WRITE in ACTIVE with RA==open_row store DQ into {open_row, CA} at that same edge.
REQ-022 SHALL on READ in ACTIVE with RA==open_row drive mem[{open_row, CA}] on DQ with rd_vld=1 exactly 2 cycles after the READ cycle (CL=2), for one cycle.
REQ-023 SHALL pipeline reads so that back-to-back READs produce back-to-back data cycles.
REQ-024 SHALL tri-state DQ in every cycle where rd_vld=0.
REQ-025 SHALL on REFRESH in IDLE enter RFSH with busy=1 for cycles t+1..t+4, then return to IDLE; a command at t+5 is accepted.
REQ-026 SHALL ignore (no state or memory change) any command raising an error.
REQ-027 SHALL raise err_vld in the cycle after the offending command, with err_code: 1 READ/WRITE in IDLE; 2 ACT with a row open; 3 REFRESH with a row open; 4 any non-NOP while busy; 5 reserved opcode; 6 READ/WRITE with RA!=open_row; 7 WRITE in a cycle where rd_vld=1 (bus conflict).
REQ-028 SHALL, when several codes apply, report the priority order 4, 5, 7, 1, 2, 3, 6.
REQ-029 SHALL increment err_cnt on each err_vld, saturating at 255.
REQ-030 SHALL count cycles since reset or the last accepted REFRESH; on reaching 400, set refresh_late and hold the counter; an accepted REFRESH clears both.
REQ-031 SHALL let an in-flight read complete its data cycle while the device is busy or after a PRE.

Reset
REQ-032 SHALL on rst_n=0 immediately set state IDLE, row_open=0, open_row=0, busy=0, rd_vld=0, DQ released, err_vld=0, err_code=0, err_cnt=0, refresh_late=0, refresh counter=0, and discard pending reads.
REQ-033 SHALL accept a command in the first cycle after rst_n deasserts.

Verification
REQ-034 Sequence ACT RA=3; WRITE RA=3 CA=0x010 DQ=0xDEADBEEF; READ RA=3 CA=0x010 -> DQ=0xDEADBEEF, rd_vld=1 exactly 2 cycles after the READ, no err_vld.
REQ-035 Two consecutive READs at CA=0x001 and 0x002 holding 0x11, 0x22 -> rd_vld high 2 consecutive cycles carrying 0x11 then 0x22.
REQ-036 Sequence READ in IDLE; ACT RA=1 then ACT RA=2; WRITE RA=5 while row 1 is open -> err_code 1, 2, 6, err_cnt=3, open_row stays 1.
REQ-037 REFRESH at cycle t, ACT at t+2 -> err_code 4 and ACT ignored; ACT at t+5 -> accepted, row_open=1 at t+6.
REQ-038 No REFRESH for 400 cycles -> refresh_late=1; REFRESH -> refresh_late=0 the next cycle.
REQ-039 Assert rst_n=0 one cycle after a READ -> DQ Z and rd_vld=0 immediately; no data cycle occurs after release.

Source files
------------

// File: rtl/mem_dev.sv
// mem_dev: single-bank memory device with ACT/PRE row handling, CL=2 pipelined
// reads, a 4-cycle refresh, protocol-error reporting and refresh-interval watchdog.
module mem_dev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [2:0]  command,
    input  logic [3:0]  RA,
    input  logic [11:0] CA,
    inout  wire  [31:0] DQ,
    output logic        rd_vld,
    output logic        row_open,
    output logic [3:0]  open_row,
    output logic        busy,
    output logic        err_vld,
    output logic [2:0]  err_code,
    output logic [7:0]  err_cnt,
    output logic        refresh_late
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ACT   = 3'b001;
    localparam logic [2:0] OP_READ  = 3'b010;
    localparam logic [2:0] OP_WRITE = 3'b011;
    localparam logic [2:0] OP_PRE   = 3'b100;
    localparam logic [2:0] OP_REF   = 3'b101;

    // Refresh occupies four busy cycles after the REFRESH command.
    localparam logic [1:0] RFSH_LAST = 2'd3;
    localparam logic [8:0] REF_LIMIT = 9'd400;

    typedef enum logic [1:0] {IDLE, ACTIVE, RFSH} state_t;

    state_t      state_q;
    logic        row_open_q;
    logic [3:0]  open_row_q;
    logic        busy_q;
    logic [1:0]  rfsh_cnt_q;
    logic        err_vld_q;
    logic [2:0]  err_code_q;
    logic [7:0]  err_cnt_q;
    logic [8:0]  ref_cnt_q;
    logic        late_q;
    logic        rd_p1_q;
    logic        rd_vld_q;
    logic [31:0] rd_dat1_q;
    logic [31:0] rd_dat2_q;

    logic [31:0] mem [0:65535];

    logic        cmd_vld;
    logic        is_rw;
    logic [2:0]  err_d;
    logic        cmd_ok;
    logic        acc_act, acc_pre, acc_rd, acc_wr, acc_ref;
    logic [15:0] addr;

    assign addr = {open_row_q, CA};

    // Classify the current command: error cause (highest priority first) and accept strobes.
    always_comb begin
        cmd_vld = !cs_n && (command != OP_NOP);
        is_rw   = (command == OP_READ) || (command == OP_WRITE);
        err_d   = 3'd0;
        if (cmd_vld) begin
            if (state_q == RFSH)                                  err_d = 3'd4;
            else if (command[2:1] == 2'b11)                       err_d = 3'd5;
            else if ((command == OP_WRITE) && rd_vld_q)           err_d = 3'd7;
            else if (is_rw && (state_q == IDLE))                  err_d = 3'd1;
            else if ((command == OP_ACT) && (state_q == ACTIVE))  err_d = 3'd2;
            else if ((command == OP_REF) && (state_q == ACTIVE))  err_d = 3'd3;
            else if (is_rw && (RA != open_row_q))                 err_d = 3'd6;
        end
        cmd_ok  = cmd_vld && (err_d == 3'd0);
        acc_act = cmd_ok && (command == OP_ACT);
        acc_pre = cmd_ok && (command == OP_PRE);
        acc_rd  = cmd_ok && (command == OP_READ);
        acc_wr  = cmd_ok && (command == OP_WRITE);
        acc_ref = cmd_ok && (command == OP_REF);
    end

    // Control FSM, error reporting, refresh watchdog and read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_open_q <= 1'b0;
            open_row_q <= 4'd0;
            busy_q     <= 1'b0;
            rfsh_cnt_q <= 2'd0;
            err_vld_q  <= 1'b0;
            err_code_q <= 3'd0;
            err_cnt_q  <= 8'd0;
            ref_cnt_q  <= 9'd0;
            late_q     <= 1'b0;
            rd_p1_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            err_vld_q  <= (err_d != 3'd0);
            err_code_q <= err_d;
            if ((err_d != 3'd0) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end

            rd_p1_q  <= acc_rd;
            rd_vld_q <= rd_p1_q;

            if (acc_ref) begin
                ref_cnt_q <= 9'd0;
                late_q    <= 1'b0;
            end else if (ref_cnt_q != REF_LIMIT) begin
                ref_cnt_q <= ref_cnt_q + 9'd1;
                if (ref_cnt_q == REF_LIMIT - 9'd1) begin
                    late_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (acc_act) begin
                        state_q    <= ACTIVE;
                        row_open_q <= 1'b1;
                        open_row_q <= RA;
                    end else if (acc_ref) begin
                        state_q    <= RFSH;
                        busy_q     <= 1'b1;
                        rfsh_cnt_q <= RFSH_LAST;
                    end
                end
                ACTIVE: begin
                    if (acc_pre) begin
                        state_q    <= IDLE;
                        row_open_q <= 1'b0;
                    end
                end
                RFSH: begin
                    if (rfsh_cnt_q == 2'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rfsh_cnt_q <= rfsh_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    row_open_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Array write and two-stage read data path (data captured at the READ edge).
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem[addr] <= DQ;
        end
        if (acc_rd) begin
            rd_dat1_q <= mem[addr];
        end
        rd_dat2_q <= rd_dat1_q;
    end

    assign DQ           = rd_vld_q ? rd_dat2_q : 32'hzzzz_zzzz;
    assign rd_vld       = rd_vld_q;
    assign row_open     = row_open_q;
    assign open_row     = open_row_q;
    assign busy         = busy_q;
    assign err_vld      = err_vld_q;
    assign err_code     = err_code_q;
    assign err_cnt      = err_cnt_q;
    assign refresh_late = late_q;

endmodule

// File: tb/tb_mem_dev.sv
// tb_mem_dev: directed stimulus with a cycle-level behavioural model and an
// every-cycle compare process, plus hand-computed spot checks.
module tb_mem_dev;

    localparam logic [2:0] NOP = 3'b000, ACT = 3'b001, RD = 3'b010, WR = 3'b011,
                           PRE = 3'b100, REF = 3'b101, RSV6 = 3'b110, RSV7 = 3'b111;
    localparam logic [31:0] REL = 32'hFFFF_FFFF;  // released bus reads as pulled-up

    logic        clk = 1'b0;
    logic        rst_n, cs_n;
    logic [2:0]  command;
    logic [3:0]  RA;
    logic [11:0] CA;
    tri1  [31:0] DQ;
    logic        tb_drv;
    logic [31:0] tb_dq;
    logic        rd_vld, row_open, busy, err_vld, refresh_late;
    logic [3:0]  open_row;
    logic [2:0]  err_code;
    logic [7:0]  err_cnt;

    assign DQ = tb_drv ? tb_dq : 32'hzzzz_zzzz;

    mem_dev dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .command(command), .RA(RA), .CA(CA),
        .DQ(DQ), .rd_vld(rd_vld), .row_open(row_open), .open_row(open_row),
        .busy(busy), .err_vld(err_vld), .err_code(err_code), .err_cnt(err_cnt),
        .refresh_late(refresh_late)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [31:0] d; bit known; } rd_t;
    rd_t         m_rdq[$];
    logic [31:0] m_mem [int];
    int          m_cyc = 0;
    int          m_busy_end, m_err, m_cnt, m_since;
    bit          m_row_open;
    logic [3:0]  m_open_row;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rdq.delete();
        m_busy_end = 0;
        m_err      = 0;
        m_cnt      = 0;
        m_since    = 0;
        m_row_open = 0;
        m_open_row = 4'd0;
    endtask

    function automatic bit due_now(input int c, output logic [31:0] d, output bit k);
        due_now = 0;
        d = 32'd0;
        k = 0;
        foreach (m_rdq[i]) begin
            if (m_rdq[i].due == c) begin
                due_now = 1;
                d = m_rdq[i].d;
                k = m_rdq[i].known;
            end
        end
    endfunction

    // Advance the model by one clock using the inputs present at this edge.
    task automatic model_step();
        bit          vld, rw, bsy, rdv, kk, acc;
        logic [31:0] dd;
        int          code, a;
        rd_t         e;
        if (!rst_n) begin
            model_reset();
            m_cyc++;
            return;
        end
        vld  = !cs_n && (command != NOP);
        rw   = (command == RD) || (command == WR);
        bsy  = m_cyc < m_busy_end;
        rdv  = due_now(m_cyc, dd, kk);
        code = 0;
        if (vld) begin
            if (bsy)                                 code = 4;
            else if (command == RSV6 || command == RSV7) code = 5;
            else if (command == WR && rdv)           code = 7;
            else if (rw && !m_row_open)              code = 1;
            else if (command == ACT && m_row_open)   code = 2;
            else if (command == REF && m_row_open)   code = 3;
            else if (rw && RA != m_open_row)         code = 6;
        end
        acc = vld && (code == 0);
        a   = int'({m_open_row, CA});
        if (acc) begin
            case (command)
                ACT: begin m_row_open = 1; m_open_row = RA; end
                PRE: m_row_open = 0;
                RD: begin
                    e.due   = m_cyc + 2;
                    e.known = m_mem.exists(a);
                    e.d     = e.known ? m_mem[a] : 32'd0;
                    m_rdq.push_back(e);
                end
                WR:  m_mem[a] = tb_dq;
                REF: m_busy_end = m_cyc + 5;
                default: ;
            endcase
        end
        if (acc && command == REF) m_since = 0;
        else if (m_since < 400)    m_since++;
        m_err = code;
        if (code != 0 && m_cnt < 255) m_cnt++;
        m_cyc++;
        while (m_rdq.size() > 0 && m_rdq[0].due < m_cyc) void'(m_rdq.pop_front());
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [31:0] dd;
        bit          kk, rv;
        forever begin
            @(negedge clk);
            rv = due_now(m_cyc, dd, kk);
            cmp("rd_vld", {31'd0, rd_vld}, {31'd0, rv});
            if (!tb_drv) begin
                if (rv && kk)  cmp("DQ_data", DQ, dd);
                else if (!rv)  cmp("DQ_released", DQ, REL);
            end
            cmp("row_open", {31'd0, row_open}, {31'd0, m_row_open});
            cmp("open_row", {28'd0, open_row}, {28'd0, m_open_row});
            cmp("busy", {31'd0, busy}, {31'd0, (m_cyc < m_busy_end)});
            cmp("err_vld", {31'd0, err_vld}, {31'd0, (m_err != 0)});
            if (m_err != 0) cmp("err_code", {29'd0, err_code}, m_err);
            cmp("err_cnt", {24'd0, err_cnt}, m_cnt);
            cmp("refresh_late", {31'd0, refresh_late}, {31'd0, (m_since >= 400)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] ra, input logic [11:0] ca,
                         input logic [31:0] d = 32'd0, input logic csn = 1'b0);
        cs_n    = csn;
        command = op;
        RA      = ra;
        CA      = ca;
        tb_dq   = d;
        tb_drv  = (op == WR) && !csn;
        tick();
        cs_n    = 1'b1;
        command = NOP;
        tb_drv  = 1'b0;
    endtask

    task automatic nops(input int n);
        repeat (n) issue(NOP, 4'd0, 12'd0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; cs_n = 1'b1; command = NOP; RA = 4'd0; CA = 12'd0;
        tb_drv = 1'b0; tb_dq = 32'd0;
        model_reset();
        repeat (3) tick();
        at_neg();
        cmp("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        cmp("reset_row_open", {31'd0, row_open}, 32'd0);
        cmp("reset_DQ", DQ, REL);
        rst_n = 1'b1;

        // ACT in the first cycle after reset release, write/read back
        issue(ACT, 4'd3, 12'd0);
        at_neg();
        cmp("act_row_open", {31'd0, row_open}, 32'd1);
        issue(WR, 4'd3, 12'h010, 32'hDEAD_BEEF);
        issue(WR, 4'd3, 12'h001, 32'h0000_0011);
        issue(WR, 4'd3, 12'h002, 32'h0000_0022);
        issue(RD, 4'd3, 12'h010);
        at_neg();
        cmp("cl2_not_early", {31'd0, rd_vld}, 32'd0);
        issue(NOP, 4'd0, 12'd0);
        at_neg();
        cmp("cl2_rd_vld", {31'd0, rd_vld}, 32'd1);
        cmp("cl2_data", DQ, 32'hDEAD_BEEF);
        cmp("cl2_no_err", {31'd0, err_vld}, 32'd0);

        // back-to-back reads
        issue(RD, 4'd3, 12'h001);
        issue(RD, 4'd3, 12'h002);
        at_neg();
        cmp("b2b_first", DQ, 32'h0000_0011);
        issue(NOP, 4'd0, 12'd0);
        at_neg();
        cmp("b2b_second", DQ, 32'h0000_0022);
        cmp("b2b_vld", {31'd0, rd_vld}, 32'd1);
        issue(PRE, 4'd0, 12'd0);

        // protocol errors 1, 2, 6
        issue(RD, 4'd0, 12'd0);
        at_neg();
        cmp("err1_code", {29'd0, err_code}, 32'd1);
        issue(ACT, 4'd1, 12'd0);
        issue(ACT, 4'd2, 12'd0);
        at_neg();
        cmp("err2_code", {29'd0, err_code}, 32'd2);
        issue(WR, 4'd5, 12'd0, 32'h0000_0055);
        at_neg();
        cmp("err6_code", {29'd0, err_code}, 32'd6);
        cmp("err_cnt_3", {24'd0, err_cnt}, 32'd3);
        cmp("open_row_kept", {28'd0, open_row}, 32'd1);
        issue(REF, 4'd0, 12'd0);
        at_neg();
        cmp("err3_code", {29'd0, err_code}, 32'd3);

        // in-flight read completes after PRE
        issue(WR, 4'd1, 12'h004, 32'hA5A5_0004);
        issue(RD, 4'd1, 12'h004);
        issue(PRE, 4'd0, 12'd0);
        at_neg();
        cmp("pre_read_data", DQ, 32'hA5A5_0004);
        cmp("pre_row_closed", {31'd0, row_open}, 32'd0);

        // WRITE in IDLE during a data cycle: bus conflict outranks IDLE access
        issue(ACT, 4'd1, 12'd0);
        issue(RD, 4'd1, 12'h004);
        issue(PRE, 4'd0, 12'd0);
        issue(WR, 4'd1, 12'h004, 32'h0BAD_0BAD);
        at_neg();
        cmp("err7_code", {29'd0, err_code}, 32'd7);
        issue(RSV7, 4'd0, 12'd0);
        at_neg();
        cmp("err5_code", {29'd0, err_code}, 32'd5);
        issue(RSV6, 4'd0, 12'd0, 32'd0, 1'b1);
        at_neg();
        cmp("deselect_no_err", {31'd0, err_vld}, 32'd0);

        // refresh busy window
        issue(REF, 4'd0, 12'd0);
        at_neg();
        cmp("rfsh_busy", {31'd0, busy}, 32'd1);
        issue(NOP, 4'd0, 12'd0);
        issue(ACT, 4'd2, 12'd0);
        at_neg();
        cmp("err4_code", {29'd0, err_code}, 32'd4);
        cmp("busy_act_ignored", {31'd0, row_open}, 32'd0);
        issue(RSV6, 4'd0, 12'd0);
        at_neg();
        cmp("err4_over_5", {29'd0, err_code}, 32'd4);
        issue(NOP, 4'd0, 12'd0);
        at_neg();
        cmp("rfsh_done", {31'd0, busy}, 32'd0);
        issue(ACT, 4'd6, 12'd0);
        at_neg();
        cmp("act_after_rfsh", {31'd0, row_open}, 32'd1);
        cmp("act_after_rfsh_row", {28'd0, open_row}, 32'd6);
        issue(PRE, 4'd0, 12'd0);

        // refresh-interval watchdog
        issue(REF, 4'd0, 12'd0);
        nops(399);
        at_neg();
        cmp("late_at_399", {31'd0, refresh_late}, 32'd0);
        issue(NOP, 4'd0, 12'd0);
        at_neg();
        cmp("late_at_400", {31'd0, refresh_late}, 32'd1);
        issue(REF, 4'd0, 12'd0);
        at_neg();
        cmp("late_cleared", {31'd0, refresh_late}, 32'd0);
        nops(4);

        // error counter saturation
        for (int i = 0; i < 260; i++) issue(RSV6, 4'd0, 12'd0);
        at_neg();
        cmp("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // asynchronous reset during a data cycle
        issue(ACT, 4'd3, 12'd0);
        issue(RD, 4'd3, 12'h001);
        issue(RD, 4'd3, 12'h002);
        at_neg();
        cmp("pre_reset_vld", {31'd0, rd_vld}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
        cmp("rst_DQ", DQ, REL);
        cmp("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        cmp("rst_row_open", {31'd0, row_open}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        nops(4);
        issue(ACT, 4'd3, 12'd0);
        at_neg();
        cmp("post_rst_act", {31'd0, row_open}, 32'd1);
        nops(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
